// File: rtl/vec_pkg.sv
// Shared vector-path definitions: default element width/lane count and the
// result serializer state encoding.
package vec_pkg;

  localparam int unsigned VEC_BITS = 8;
  localparam int unsigned VEC_N    = 64;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } ser_state_t;

  // Index/length counter width: must be able to hold N itself, not just N-1.
  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/vector_result_serializer.sv
// Snapshots an ALU result vector on start and streams its first min(S_len, N)
// elements out over a valid/ready link, then pulses done.
module vector_result_serializer
  import vec_pkg::*;
#(
  parameter int unsigned BITS = VEC_BITS,
  parameter int unsigned N    = VEC_N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] S [N],
  input  logic [BITS-1:0] S_len,
  output logic            busy,
  output logic [BITS-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            done
);

  localparam int unsigned IDX_W = idx_width(N);
  localparam int unsigned AW    = $clog2(N);
  localparam int unsigned CW    = (BITS > IDX_W) ? BITS : IDX_W;

  ser_state_t       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] len_q;
  logic [BITS-1:0]  snap_q [N];

  logic [CW-1:0]    s_len_ext;
  logic [IDX_W-1:0] len_cap;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] len_last;
  logic             capture;

  always_comb begin
    s_len_ext = CW'(S_len);
    if (s_len_ext > CW'(N)) begin
      len_cap = IDX_W'(N);
    end else begin
      len_cap = IDX_W'(S_len);
    end
    idx_next = idx_q + 1'b1;
    len_last = len_q - 1'b1;
    capture  = (state_q == IDLE) && start;
  end

  // Snapshot contents are don't-care out of reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (capture) begin
      snap_q <= S;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q <= '0;
            len_q <= len_cap;
            busy  <= 1'b1;
            if (len_cap == '0) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              // First beat comes straight from S; snap_q is written on this same edge.
              state_q   <= STREAM;
              out_valid <= 1'b1;
              out_data  <= S[0];
              out_last  <= (len_cap == IDX_W'(1));
            end
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              state_q   <= DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              done      <= 1'b1;
            end else begin
              idx_q    <= idx_next;
              out_data <= snap_q[idx_next[AW-1:0]];
              out_last <= (idx_next == len_last);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_result_serializer.sv
// Directed bench for vector_result_serializer: table of stream scenarios run
// back-to-back, plus reset checks and an asynchronous mid-stream reset.
module tb_vector_result_serializer;

  localparam int unsigned BITS = 8;
  localparam int unsigned N    = 64;

  logic            clk;
  logic            rst;
  logic            start;
  logic [BITS-1:0] s_arr [N];
  logic [BITS-1:0] s_len;
  logic            busy;
  logic [BITS-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            done;

  int checks   = 0;
  int failures = 0;

  vector_result_serializer #(
    .BITS(BITS),
    .N   (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .S        (s_arr),
    .S_len    (s_len),
    .busy     (busy),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One scenario: S[i] = base + i, cycles counted from the start edge.
  typedef struct {
    int unsigned len;
    int unsigned base;
    int          stall_from;
    int          stall_to;
    int          poke;
    int unsigned exp_beats;
    int unsigned exp_last;
    int          exp_lat;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill_s(input int unsigned base);
    for (int i = 0; i < N; i++) s_arr[i] = 8'((base + i) & 8'hff);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after done.
  task automatic run_vec(input vec_t v);
    int unsigned beats;
    int          cyc;
    bit          got_done;
    fill_s(v.base);
    s_len     = 8'(v.len);
    out_ready = 1'b1;
    start     = 1'b1;
    beats     = 0;
    got_done  = 1'b0;
    cyc       = 0;
    while (cyc < 200 && !got_done) begin
      @(negedge clk);
      cyc++;
      start     = 1'b0;
      out_ready = !(cyc >= v.stall_from && cyc <= v.stall_to && v.stall_from > 0);
      if (cyc == v.poke) begin
        for (int i = 0; i < N; i++) s_arr[i] = 8'hff;
        start = 1'b1;
      end
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (out_valid) begin
        check("beat_data", out_data, (v.base + beats) & 8'hff);
        check("beat_last", out_last, (beats == v.exp_beats - 1) ? 1 : 0);
        if (out_ready) begin
          if (out_last) check("last_data", out_data, v.exp_last);
          beats++;
        end
      end
      if (done) begin
        got_done = 1'b1;
        check("done_latency", cyc, v.exp_lat);
        check("busy_in_done", busy, 1);
        check("valid_in_done", out_valid, 0);
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    check("beat_count", beats, v.exp_beats);
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_valid", out_valid, 0);
  endtask

  initial begin
    //           len  base stall   poke beats last lat
    tbl[0] = '{  5,   1,  0, 0,   0,   5,   5,   6};  // basic
    tbl[1] = '{  3,   1,  2, 3,   0,   3,   3,   6};  // backpressure on beat 2
    tbl[2] = '{  0,   1,  0, 0,   0,   0,   0,   1};  // empty request
    tbl[3] = '{200,   1,  0, 0,   0,  64,  64,  65};  // clamp to N
    tbl[4] = '{  4,   1,  0, 0,   2,   4,   4,   5};  // overwrite S + start mid-stream
    tbl[5] = '{  5,   1,  0, 0,   6,   5,   5,   6};  // start during DONE
    tbl[6] = '{  1,   9,  0, 0,   0,   1,   9,   2};  // single element
    tbl[7] = '{ 64, 100,  0, 0,   0,  64, 163,  65};  // exactly N
    tbl[8] = '{ 65,   0,  0, 0,   0,  64,  63,  65};  // N+1 clamps

    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    s_len     = '0;
    fill_s(0);
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 9; k++) run_vec(tbl[k]);

    // Asynchronous reset while beat 3 of 10 is on the link.
    fill_s(1);
    s_len     = 8'd10;
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_data", out_data, 3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    run_vec(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
